// File: rtl/hsv2rgb_pkg.sv
// Shared types and constant helpers for the HSV->RGB pipeline.
// Rounding mode is selected by HSV2RGB_ROUND_EN in hsv2rgb_scale.
package hsv2rgb_pkg;

   typedef enum logic [2:0] {
      REG_0 = 3'd0,
      REG_1 = 3'd1,
      REG_2 = 3'd2,
      REG_3 = 3'd3,
      REG_4 = 3'd4,
      REG_5 = 3'd5
   } region_t;

   // Hue span of one 60-degree sector: ceil(2^w/6)
   function automatic int unsigned sector(input int unsigned w);
      return ((32'd1 << w) + 32'd5) / 32'd6;
   endfunction

   function automatic int unsigned max_val(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/hsv2rgb_scale.sv
// W x W multiply followed by >>W; HSV2RGB_ROUND_EN selects round-half-up
// with saturation to 2^W-1, otherwise plain truncation.
module hsv2rgb_scale #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_y
);

   logic [2*W-1:0] w_prod;

   assign w_prod = (2*W)'(i_a) * (2*W)'(i_b);

`ifdef HSV2RGB_ROUND_EN
   localparam logic [2*W:0] C_HALF = (2*W+1)'(1) << (W-1);

   logic [2*W:0] w_sum;
   logic [W:0]   w_shr;

   assign w_sum = {1'b0, w_prod} + C_HALF;
   assign w_shr = (W+1)'(w_sum >> W);
   assign o_y   = w_shr[W] ? {W{1'b1}} : w_shr[W-1:0];
`else
   assign o_y = W'(w_prod >> W);
`endif

endmodule

// File: rtl/hsv2rgb_pipe.sv
// Three-stage HSV->RGB converter with valid/ready on both sides and a
// sideband tag. Build macro: HSV2RGB_ROUND_EN (rounding in hsv2rgb_scale).
module hsv2rgb_pipe
   import hsv2rgb_pkg::*;
#(
   parameter int unsigned W      = 8,
   parameter int unsigned USER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_hue,
   input  logic [W-1:0]      in_sat,
   input  logic [W-1:0]      in_val,
   input  logic [USER_W-1:0] in_user,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3*W-1:0]    out_rgb,
   output logic [USER_W-1:0] out_user
);

   localparam int unsigned SECTOR = sector(W);
   localparam int unsigned HW     = W + 3;
   localparam logic [W-1:0] C_MAX = W'(max_val(W));

   logic w_adv;

   // Stage 1 registers
   logic              r1_valid;
   region_t           r1_region;
   logic [W-1:0]      r1_rem;
   logic [W-1:0]      r1_rem_n;
   logic [W-1:0]      r1_sat_n;
   logic [W-1:0]      r1_val;
   logic [USER_W-1:0] r1_user;

   // Stage 2 registers
   logic              r2_valid;
   region_t           r2_region;
   logic [W-1:0]      r2_p;
   logic [W-1:0]      r2_q;
   logic [W-1:0]      r2_t;
   logic [W-1:0]      r2_val;
   logic [USER_W-1:0] r2_user;

   logic [2:0]    w_region_idx;
   logic [HW-1:0] w_base;
   logic [W-1:0]  w_rem;

   logic [W-1:0]   w_sat;
   logic [W-1:0]   w_sr;
   logic [W-1:0]   w_srn;
   logic [W-1:0]   w_sr_n;
   logic [W-1:0]   w_srn_n;
   logic [W-1:0]   w_p;
   logic [W-1:0]   w_q;
   logic [W-1:0]   w_t;
   logic [3*W-1:0] w_rgb;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   // Region by threshold compare instead of a divider; tops out at 5 by construction
   always_comb begin
      w_region_idx = 3'd0;
      for (int k = 1; k <= 5; k++) begin
         if (HW'(in_hue) >= HW'(k * SECTOR)) begin
            w_region_idx = 3'(k);
         end
      end
      w_base = HW'(w_region_idx) * HW'(SECTOR);
      w_rem  = W'((HW'(in_hue) - w_base) * HW'(6));
   end

   assign w_sat   = ~r1_sat_n;
   assign w_sr_n  = C_MAX - w_sr;
   assign w_srn_n = C_MAX - w_srn;

   hsv2rgb_scale #(.W(W)) u_scale_p   (.i_a(r1_val), .i_b(r1_sat_n), .o_y(w_p));
   hsv2rgb_scale #(.W(W)) u_scale_sr  (.i_a(w_sat),  .i_b(r1_rem),   .o_y(w_sr));
   hsv2rgb_scale #(.W(W)) u_scale_srn (.i_a(w_sat),  .i_b(r1_rem_n), .o_y(w_srn));
   hsv2rgb_scale #(.W(W)) u_scale_q   (.i_a(r1_val), .i_b(w_sr_n),   .o_y(w_q));
   hsv2rgb_scale #(.W(W)) u_scale_t   (.i_a(r1_val), .i_b(w_srn_n),  .o_y(w_t));

   always_comb begin
      w_rgb = {r2_p, r2_t, r2_val};
      case (r2_region)
         REG_0:   w_rgb = {r2_p,   r2_t,   r2_val};
         REG_1:   w_rgb = {r2_p,   r2_val, r2_q  };
         REG_2:   w_rgb = {r2_t,   r2_val, r2_p  };
         REG_3:   w_rgb = {r2_val, r2_q,   r2_p  };
         REG_4:   w_rgb = {r2_val, r2_p,   r2_t  };
         REG_5:   w_rgb = {r2_q,   r2_p,   r2_val};
         default: w_rgb = {r2_p,   r2_t,   r2_val};
      endcase
   end

   // All stages move together; a stall freezes the whole pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_valid  <= 1'b0;
         r1_region <= REG_0;
         r1_rem    <= '0;
         r1_rem_n  <= '0;
         r1_sat_n  <= '0;
         r1_val    <= '0;
         r1_user   <= '0;
         r2_valid  <= 1'b0;
         r2_region <= REG_0;
         r2_p      <= '0;
         r2_q      <= '0;
         r2_t      <= '0;
         r2_val    <= '0;
         r2_user   <= '0;
         out_valid <= 1'b0;
         out_rgb   <= '0;
         out_user  <= '0;
      end else if (w_adv) begin
         r1_valid  <= in_valid;
         r1_region <= region_t'(w_region_idx);
         r1_rem    <= w_rem;
         r1_rem_n  <= C_MAX - w_rem;
         r1_sat_n  <= C_MAX - in_sat;
         r1_val    <= in_val;
         r1_user   <= in_user;
         r2_valid  <= r1_valid;
         r2_region <= r1_region;
         r2_p      <= w_p;
         r2_q      <= w_q;
         r2_t      <= w_t;
         r2_val    <= r1_val;
         r2_user   <= r1_user;
         out_valid <= r2_valid;
         out_rgb   <= w_rgb;
         out_user  <= r2_user;
      end
   end

endmodule
